// File: rtl/mem_master_pkg.sv
// Shared definitions for mem_master: FSM state encoding, read-latency limits
// and the byte-lane merge used by sub-word stores.
package mem_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        MERGE,
        WR,
        RESP
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Enabled byte lanes come from new_w, the rest keep old_w.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] w;
        w = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) w[8*i +: 8] = new_w[8*i +: 8];
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_master.sv
// Single-outstanding CPU-to-memory request master with range checking.
// Define MEM_MASTER_SUBWORD_EN to enable byte-enable stores via read-modify-write.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int MEM_WORDS = 257,
    parameter int RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out,
    output logic        mem_read_sig,
    output logic        mem_wrt_sig
);

    localparam int                CNT_W     = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(1);
    localparam logic [31:0]       MEM_LIMIT = 32'(MEM_WORDS);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("mem_master: RD_LAT out of range");
    end

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              wr_q;
    logic [31:0]       addr_q;
    logic [31:0]       mem_in_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              oob;

    assign oob = (req_addr >= MEM_LIMIT);

`ifdef MEM_MASTER_SUBWORD_EN
    logic [3:0]  be_q;
    logic [31:0] rmw_q;
`else
    logic unused_be;
    assign unused_be = ^req_be;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            mem_in_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef MEM_MASTER_SUBWORD_EN
            be_q     <= '0;
            rmw_q    <= '0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req_valid) begin
                    addr_q   <= req_addr;
                    wr_q     <= req_wr;
                    mem_in_q <= req_wdata;
                    err_q    <= oob;
`ifdef MEM_MASTER_SUBWORD_EN
                    be_q     <= req_be;
`endif
                end
                RD_ISSUE: cnt <= CNT_LOAD;
                RD_WAIT: begin
                    cnt <= cnt - CNT_LAST;
                    // Last wait cycle: mem_out is valid now.
                    if (cnt == CNT_LAST && !wr_q) rdata_q <= mem_out;
`ifdef MEM_MASTER_SUBWORD_EN
                    if (cnt == CNT_LAST && wr_q) rmw_q <= mem_out;
`endif
                end
`ifdef MEM_MASTER_SUBWORD_EN
                MERGE: mem_in_q <= merge_bytes(rmw_q, mem_in_q, be_q);
`endif
                RESP: if (resp_ready) begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx     = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_read_sig = 1'b0;
        mem_wrt_sig  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (oob)                  state_nx = RESP;
                    else if (!req_wr)         state_nx = RD_ISSUE;
`ifdef MEM_MASTER_SUBWORD_EN
                    else if (req_be == 4'h0)  state_nx = RESP;
                    else if (req_be != 4'hF)  state_nx = RD_ISSUE;
`endif
                    else                      state_nx = WR;
                end
            end
            RD_ISSUE: begin
                mem_read_sig = 1'b1;
                state_nx     = RD_WAIT;
            end
            RD_WAIT: if (cnt == CNT_LAST) begin
`ifdef MEM_MASTER_SUBWORD_EN
                state_nx = wr_q ? MERGE : RESP;
`else
                state_nx = RESP;
`endif
            end
`ifdef MEM_MASTER_SUBWORD_EN
            MERGE: state_nx = WR;
`endif
            WR: begin
                mem_wrt_sig = 1'b1;
                state_nx    = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem_addr   = addr_q;
    assign mem_in     = mem_in_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed self-checking bench for mem_master with a behavioural memory whose
// read data is valid for exactly one cycle, RD_LAT edges after the strobe.
module tb_mem_master;

    localparam int MEM_WORDS = 257;
    localparam int L         = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_in, mem_out;
    logic        mem_read_sig, mem_wrt_sig;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] rd_pipe [L];
    logic        tie;
    logic [31:0] exp9;

    int n_chk  = 0;
    int n_fail = 0;

    mem_master #(.MEM_WORDS(MEM_WORDS), .RD_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out),
        .mem_read_sig(mem_read_sig), .mem_wrt_sig(mem_wrt_sig)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wrt_sig && mem_addr < 32'(MEM_WORDS)) mem[mem_addr[8:0]] <= mem_in;
        rd_pipe[0] <= (mem_read_sig && mem_addr < 32'(MEM_WORDS)) ? mem[mem_addr[8:0]] : 32'hBAD0_BAD0;
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_out = rd_pipe[L-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_req_ready"},    32'(req_ready),    32'd1);
        chk({nm, "_resp_valid"},   32'(resp_valid),   32'd0);
        chk({nm, "_resp_err"},     32'(resp_err),     32'd0);
        chk({nm, "_resp_rdata"},   resp_rdata,        32'd0);
        chk({nm, "_mem_addr"},     mem_addr,          32'd0);
        chk({nm, "_mem_in"},       mem_in,            32'd0);
        chk({nm, "_mem_read_sig"}, 32'(mem_read_sig), 32'd0);
        chk({nm, "_mem_wrt_sig"},  32'(mem_wrt_sig),  32'd0);
    endtask

    // One transaction; *_k are cycles after the accept edge (0 = no strobe).
    task automatic txn(input string nm, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold,
                       input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_rd_k, input int exp_wr_k);
        int lat, rd_k, wr_k, n_strb, both;
        @(negedge clk);
        chk({nm, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        lat = 0; rd_k = 0; wr_k = 0; n_strb = 0; both = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (mem_read_sig) begin rd_k = k; n_strb++; end
            if (mem_wrt_sig)  begin wr_k = k; n_strb++; end
            if (mem_read_sig && mem_wrt_sig) both++;
            if (resp_valid) lat = k;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_rdata"}, resp_rdata, exp_rdata);
        chk({nm, "_err"}, 32'(resp_err), 32'(exp_err));
        chk({nm, "_rd_cycle"}, 32'(rd_k), 32'(exp_rd_k));
        chk({nm, "_wr_cycle"}, 32'(wr_k), 32'(exp_wr_k));
        chk({nm, "_strobes"}, 32'(n_strb), 32'((exp_rd_k != 0) + (exp_wr_k != 0)));
        chk({nm, "_overlap"}, 32'(both), 32'd0);
        if (lat != 0) begin
            if (hold > 0) begin
                req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'd5;
                for (int i = 0; i < hold; i++) begin
                    @(negedge clk);
                    chk({nm, "_hold_rdata"}, resp_rdata, exp_rdata);
                    chk({nm, "_hold_valid"}, 32'(resp_valid), 32'd1);
                    chk({nm, "_hold_ready"}, 32'(req_ready), 32'd0);
                end
                req_valid = 1'b0;
            end
            resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = tie;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        resp_ready = 1'b0; tie = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h5A00_0000 | 32'(i);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        txn("st5", 1'b1, 32'd5, 32'hDEAD_BEEF, 4'hF, 0, 2, 32'd0, 1'b0, 0, 1);
        chk("st5_mem", mem[5], 32'hDEAD_BEEF);
        txn("ld5", 1'b0, 32'd5, 32'd0, 4'hF, 0, 2 + L, 32'hDEAD_BEEF, 1'b0, 1, 0);
        txn("ld257", 1'b0, 32'd257, 32'd0, 4'hF, 0, 1, 32'd0, 1'b1, 0, 0);
        txn("st_oob", 1'b1, 32'hFFFF_FFF0, 32'h1234_5678, 4'hF, 0, 1, 32'd0, 1'b1, 0, 0);

        mem[9] = 32'h1122_3344;
        txn("ld9_hold", 1'b0, 32'd9, 32'd0, 4'h0, 5, 2 + L, 32'h1122_3344, 1'b0, 1, 0);

`ifdef MEM_MASTER_SUBWORD_EN
        txn("rmw9", 1'b1, 32'd9, 32'hAABB_CCDD, 4'b0010, 0, 4 + L, 32'd0, 1'b0, 1, 3 + L);
        chk("rmw9_mem", mem[9], 32'h1122_CC44);
        txn("be0", 1'b1, 32'd9, 32'hFFFF_FFFF, 4'h0, 0, 1, 32'd0, 1'b0, 0, 0);
        chk("be0_mem", mem[9], 32'h1122_CC44);
        exp9 = 32'h1122_CC44;
`else
        txn("st9_be", 1'b1, 32'd9, 32'hAABB_CCDD, 4'b0010, 0, 2, 32'd0, 1'b0, 0, 1);
        chk("st9_be_mem", mem[9], 32'hAABB_CCDD);
        exp9 = 32'hAABB_CCDD;
`endif

        // Abandon a load while in RD_WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'd5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        txn("ld5_after_rst", 1'b0, 32'd5, 32'd0, 4'hF, 0, 2 + L, 32'hDEAD_BEEF, 1'b0, 1, 0);

        tie = 1'b1;
        resp_ready = 1'b1;
        txn("b2b_ld5", 1'b0, 32'd5, 32'd0, 4'hF, 0, 2 + L, 32'hDEAD_BEEF, 1'b0, 1, 0);
        txn("b2b_ld9", 1'b0, 32'd9, 32'd0, 4'hF, 0, 2 + L, exp9, 1'b0, 1, 0);
        txn("b2b_st0", 1'b1, 32'd0, 32'h0BAD_F00D, 4'hF, 0, 2, 32'd0, 1'b0, 0, 1);
        txn("b2b_ld0", 1'b0, 32'd0, 32'd0, 4'hF, 0, 2 + L, 32'h0BAD_F00D, 1'b0, 1, 0);
        txn("b2b_ld256", 1'b0, 32'd256, 32'd0, 4'hF, 0, 2 + L, 32'h5A00_0100, 1'b0, 1, 0);
        tie = 1'b0;
        resp_ready = 1'b0;

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
